// File: rtl/qu_dmem_if.sv
// qu_dmem_if: back-end data-memory request bus plus the tagged load-return bus.
// The back end is the master; qu_dmem is the slave.
interface qu_dmem_if #(
  parameter int AW = 10,
  parameter int PW = 3
);
  logic [3:0]    wr_en;
  logic          rd_en;
  logic [31:0]   addr;
  logic [31:0]   data_in;
  logic          valid_out;
  logic [AW-1:0] valid_addr_out;
  logic [31:0]   data_out;
  logic [PW-1:0] rd_pending;
  logic          addr_err;
  modport master (
    output wr_en, rd_en, addr, data_in,
    input  valid_out, valid_addr_out, data_out, rd_pending, addr_err
  );
  modport slave (
    input  wr_en, rd_en, addr, data_in,
    output valid_out, valid_addr_out, data_out, rd_pending, addr_err
  );
endinterface

// File: rtl/qu_dmem.sv
// qu_dmem: word-organised data memory with byte-lane stores and a fixed-latency load pipeline.
// Define QU_DMEM_BOUNDS_CHECK_EN to suppress out-of-range accesses and raise a sticky addr_err.
module qu_dmem #(
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  qu_dmem_if.slave   bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(RD_LATENCY + 1) + 1;
  logic [31:0]   mem [MEM_DEPTH];
  logic [AW-1:0] idx;
  logic          oob, wr_ok, rd_ok;
  logic          vld_q [RD_LATENCY];
  logic          vld_d [RD_LATENCY];
  logic [AW-1:0] adr_q [RD_LATENCY];
  logic [AW-1:0] adr_d [RD_LATENCY];
  logic [31:0]   dat_q [RD_LATENCY];
  logic [31:0]   dat_d [RD_LATENCY];
  logic [PW-1:0] rd_pending_q, rd_pending_d;
  logic          addr_err_q, addr_err_d;
  logic          unused_lo;
  assign idx       = bus.addr[AW+1:2];
  assign unused_lo = ^bus.addr[1:0];
`ifdef QU_DMEM_BOUNDS_CHECK_EN
  assign oob = |bus.addr[31:AW+2];
`else
  logic unused_hi;
  assign oob       = 1'b0;
  assign unused_hi = ^bus.addr[31:AW+2];
`endif
  assign wr_ok = (bus.wr_en != 4'b0) && !oob;
  assign rd_ok = bus.rd_en && !oob;
  // Array has no reset; requests during reset must not write it.
  always_ff @(posedge clk) begin
    if (rst && wr_ok)
      for (int i = 0; i < 4; i++)
        if (bus.wr_en[i]) mem[idx][8*i +: 8] <= bus.data_in[8*i +: 8];
  end
  // Stage data only moves with its valid bit, so the last stage holds the last returned load.
  always_comb begin
    vld_d[0] = rd_ok;
    adr_d[0] = rd_ok ? idx : adr_q[0];
    dat_d[0] = rd_ok ? mem[idx] : dat_q[0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      adr_d[i] = vld_q[i-1] ? adr_q[i-1] : adr_q[i];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
    rd_pending_d = rd_pending_q + PW'(rd_ok) - PW'(vld_q[RD_LATENCY-1]);
    addr_err_d   = addr_err_q | (oob & (bus.rd_en | (|bus.wr_en)));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
      rd_pending_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_d[i];
        adr_q[i] <= adr_d[i];
        dat_q[i] <= dat_d[i];
      end
      rd_pending_q <= rd_pending_d;
      addr_err_q   <= addr_err_d;
    end
  end
  assign bus.valid_out      = vld_q[RD_LATENCY-1];
  assign bus.valid_addr_out = adr_q[RD_LATENCY-1];
  assign bus.data_out       = dat_q[RD_LATENCY-1];
  assign bus.rd_pending     = rd_pending_q;
  assign bus.addr_err       = addr_err_q;
endmodule

// File: doc/qu_dmem.md
# qu_dmem

Word-organised data memory for The Qu Processor, directly downstream of the back-end retire stage. It accepts one load or store per cycle on the back-end data-memory interface (byte write enables, read enable, byte address, write data). It returns load results after a fixed, parameterised read latency, tagged with the word address, on the valid/address/data return interface the back end consumes. Stores commit in the cycle they are presented; loads are pipelined.

## Interface
- `MEM_DEPTH`, default 1024: number of 32-bit words; power of two, ≥ 4. `AW = $clog2(MEM_DEPTH)`.
- `RD_LATENCY`, default 2: cycles from load acceptance to `valid_out`; legal range 1–8.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 4: byte-lane write enables; bit i writes `data_in[8i+7:8i]`.
- `rd_en` in 1: load request.
- `addr` in 32: byte address; word index = `addr[AW+1:2]`; `addr[1:0]` ignored.
- `data_in` in 32: store data.
- `valid_out` out 1: one-cycle pulse per returned load.
- `valid_addr_out` out AW: word index of the returned load.
- `data_out` out 32: returned load word.
- `rd_pending` out $clog2(RD_LATENCY+1)+1: loads accepted but not yet returned.
- `addr_err` out 1: sticky out-of-range flag (see Configuration).

## Operation
- Memory array: `MEM_DEPTH` × 32 bits, not cleared by reset; simulation contents start as X.
- Store: in any cycle with `wr_en != 0`, each enabled byte lane of word `addr[AW+1:2]` is written at that edge. Disabled lanes are unchanged.
- Load: in any cycle with `rd_en = 1`, the array word is sampled at that edge into stage 1 of a `RD_LATENCY`-deep shift pipeline, together with its word index and a valid bit. Stage `RD_LATENCY` drives the outputs.
- Same-cycle load and store: the store is performed, and the load returns the pre-store contents (read-before-write) for all lanes.
- A load in cycle N+1 to a word stored in cycle N sees the new data.
- No backpressure: one access per cycle sustained indefinitely; the pipeline always advances.
- `rd_pending` adds 1 per accepted load and subtracts 1 per `valid_out`. Simultaneous accept and return leaves it unchanged. Maximum value is `RD_LATENCY`.
- `data_out` and `valid_addr_out` hold their last value while `valid_out = 0`.

## Timing
- Load accepted at edge N → `valid_out = 1` during the cycle after edge N+RD_LATENCY−1, i.e. RD_LATENCY cycles later. Back-to-back loads return back-to-back in issue order.
- Store latency: 0. Data is visible to any load accepted at a later edge.
- Reset (`rst = 0`, asynchronous, any time including mid-pipeline):
  - all pipeline valid bits clear;
  - `valid_out = 0`, `valid_addr_out = 0`, `data_out = 0`, `rd_pending = 0`, `addr_err = 0`.
  - In-flight loads are discarded without returning. Array contents are retained.
- Requests presented while `rst = 0` are ignored, including stores.
- Reset deassertion: the first request is accepted at the first rising edge with `rst = 1`.

## Configuration
- `QU_DMEM_BOUNDS_CHECK_EN` defined:
  - any access with `addr[31:AW+2] != 0` is suppressed: no array write, and no pipeline entry for a load.
  - `addr_err` sets to 1 at that edge and stays 1 until reset.
  - A suppressed load does not increment `rd_pending`.
- Not defined: upper address bits are ignored (accesses wrap modulo MEM_DEPTH words), and `addr_err` is tied to 0.

## Test plan
- Store `wr_en=4'hF`, `addr=0x10`, `data_in=0xDEADBEEF`; load `addr=0x10` next cycle. Required: with RD_LATENCY=2, `valid_out` pulses 2 cycles after acceptance, `valid_addr_out=4`, `data_out=0xDEADBEEF`.
- Byte-lane merge: preload word 4 with 0x11223344, store `wr_en=4'b0100`, `data_in=0x00AA0000`, then load. Required: `data_out=0x11AA3344`.
- Same-cycle `rd_en=1` and `wr_en=4'hF` to word 8 holding 0x1, writing 0x2. Required: the load returns 0x1; a load issued next cycle returns 0x2.
- Loads on 4 consecutive cycles to words 0–3 (contents 0xA0–0xA3). Required: 4 consecutive `valid_out` pulses in order, data 0xA0–0xA3, and `rd_pending` peaking at RD_LATENCY.
- Reset asserted with 2 loads in flight. Required: outputs zero immediately, with no `valid_out` for those loads. After release, memory contents are intact, as checked by a reload.
- With `QU_DMEM_BOUNDS_CHECK_EN`, MEM_DEPTH=1024, store to `addr=0x1000`. Required: `addr_err=1`, word 0 unchanged, and `addr_err` holds until reset. Without the macro, the same store writes word 0.
